// File: rtl/hit_tracker_pkg.sv
// hit_tracker_pkg: game states, width helpers and default sizing for hit_tracker
package hit_tracker_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam int CELLS_DEF = 5;
    localparam int SHOTS_DEF = 8;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/hit_tracker_if.sv
// hit_tracker_if: shot request / response handshake between player decoder and hit_tracker
interface hit_tracker_if
    import hit_tracker_pkg::*;
#(
    parameter int CELLS = CELLS_DEF,
    localparam int IDXW = idx_w(CELLS)
);
    logic shot_valid;
    logic [IDXW-1:0] shot_idx;
    logic shot_ready;
    logic resp_valid;
    logic resp_hit;
    logic resp_repeat;
    modport master (output shot_valid, shot_idx, input shot_ready, resp_valid, resp_hit, resp_repeat);
    modport slave (input shot_valid, shot_idx, output shot_ready, resp_valid, resp_hit, resp_repeat);
endinterface

// File: rtl/hit_tracker_cell.sv
// hit_cell: one board cell holding its ship bit plus sticky hit and shot flags
module hit_cell (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic load,
    input  logic ship_in,
    input  logic fire,
    output logic ship,
    output logic hit,
    output logic shot
);
    logic ship_q, ship_d, hit_q, hit_d, shot_q, shot_d;
    always_comb begin
        ship_d = load ? ship_in : ship_q;
        hit_d = clear ? 1'b0 : (hit_q | (fire & ship_q));
        shot_d = clear ? 1'b0 : (shot_q | fire);
    end
    always_ff @(posedge clk) begin
        if (rstn) begin
            ship_q <= 1'b0;
            hit_q <= 1'b0;
            shot_q <= 1'b0;
        end else begin
            ship_q <= ship_d;
            hit_q <= hit_d;
            shot_q <= shot_d;
        end
    end
    assign ship = ship_q;
    assign hit = hit_q;
    assign shot = shot_q;
endmodule

// File: rtl/hit_tracker.sv
// hit_tracker: shot verification FSM with hit/budget tracking; define REPEAT_FREE_EN to make repeat shots free
module hit_tracker
    import hit_tracker_pkg::*;
#(
    parameter int CELLS = CELLS_DEF,
    parameter int SHOTS_MAX = SHOTS_DEF,
    localparam int CNTW = cnt_w(CELLS),
    localparam int SW = cnt_w(SHOTS_MAX)
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic [CELLS-1:0] map_input,
    hit_tracker_if.slave bus,
    output logic [CELLS-1:0] hits,
    output logic [CNTW-1:0] hit_count,
    output logic [SW-1:0] shots_left,
    output logic game_over,
    output logic win
);
    state_t state_q, state_d;
    logic [CELLS-1:0] ships, shot_mask, fire, hits_new, ship_sel, shot_sel;
    logic [SW-1:0] shots_left_q, shots_left_d;
    logic [CNTW-1:0] hit_count_q, hit_count_d;
    logic resp_valid_q, resp_valid_d, resp_hit_q, resp_hit_d, resp_repeat_q, resp_repeat_d;
    logic win_q, win_d;
    logic accept, in_range, is_hit, is_repeat, dec, all_hit;

    for (genvar c = 0; c < CELLS; c++) begin : g_cell
        hit_cell u_cell (
            .clk(clk), .rstn(rstn), .clear(start), .load(start), .ship_in(map_input[c]),
            .fire(fire[c]), .ship(ships[c]), .hit(hits[c]), .shot(shot_mask[c])
        );
    end

    always_comb begin
        accept = bus.shot_valid && state_q == PLAY && !start;
        in_range = int'(bus.shot_idx) < CELLS;
        ship_sel = ships >> bus.shot_idx;
        shot_sel = shot_mask >> bus.shot_idx;
        is_hit = in_range && ship_sel[0];
        is_repeat = in_range && shot_sel[0];
        fire = (accept && in_range) ? (CELLS'(1) << bus.shot_idx) : '0;
        hits_new = hits | (fire & ships);
        all_hit = (ships & ~hits_new) == '0;
`ifdef REPEAT_FREE_EN
        dec = accept && !is_repeat;
`else
        dec = accept;
`endif
        shots_left_d = start ? SW'(SHOTS_MAX) : (dec && shots_left_q != '0) ? shots_left_q - SW'(1) : shots_left_q;
        hit_count_d = '0;
        for (int i = 0; i < CELLS; i++) hit_count_d = hit_count_d + CNTW'(hits_new[i] && !start);
        state_d = state_q;
        win_d = win_q;
        if (start) begin
            state_d = (map_input == '0) ? DONE : PLAY;
            win_d = map_input == '0;
        end else if (accept && (all_hit || shots_left_d == '0)) begin
            state_d = DONE;
            win_d = all_hit;
        end
        resp_valid_d = accept;
        resp_hit_d = accept && is_hit;
        resp_repeat_d = accept && is_repeat;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
            shots_left_q <= '0;
            hit_count_q <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_repeat_q <= 1'b0;
            win_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shots_left_q <= shots_left_d;
            hit_count_q <= hit_count_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q <= resp_hit_d;
            resp_repeat_q <= resp_repeat_d;
            win_q <= win_d;
        end
    end

    assign bus.shot_ready = state_q == PLAY;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit = resp_hit_q;
    assign bus.resp_repeat = resp_repeat_q;
    assign hit_count = hit_count_q;
    assign shots_left = shots_left_q;
    assign game_over = state_q == DONE;
    assign win = win_q;
endmodule

// File: tb/tb_hit_tracker.sv
// tb_hit_tracker: directed game scenarios plus random play checked against a cell-array game model
module tb_hit_tracker;
    import hit_tracker_pkg::*;
    localparam int C = 5;
    localparam int SM = 8;
    localparam int IW = idx_w(C);
`ifdef REPEAT_FREE_EN
    localparam bit RF = 1'b1;
`else
    localparam bit RF = 1'b0;
`endif
    logic clk = 1'b0;
    logic rstn, start;
    logic [C-1:0] map_input, hits;
    logic [2:0] hit_count;
    logic [3:0] shots_left;
    logic game_over, win;

    hit_tracker_if #(.CELLS(C)) bus ();
    hit_tracker #(.CELLS(C), .SHOTS_MAX(SM)) dut (
        .clk(clk), .rstn(rstn), .start(start), .map_input(map_input), .bus(bus),
        .hits(hits), .hit_count(hit_count), .shots_left(shots_left), .game_over(game_over), .win(win)
    );
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    bit m_ship [C];
    bit m_hit [C];
    bit m_shot [C];
    int m_left, m_state, m_hits_vec, m_count;
    bit m_win, m_rv, m_rh, m_rr;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit all_sunk();
        for (int k = 0; k < C; k++) if (m_ship[k] && !m_hit[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step();
        int i;
        m_rv = 0; m_rh = 0; m_rr = 0;
        if (rstn) begin
            for (int k = 0; k < C; k++) begin m_ship[k] = 0; m_hit[k] = 0; m_shot[k] = 0; end
            m_left = 0; m_state = 0; m_win = 0;
        end else if (start) begin
            for (int k = 0; k < C; k++) begin m_ship[k] = map_input[k]; m_hit[k] = 0; m_shot[k] = 0; end
            m_left = SM;
            m_win = map_input == 0;
            m_state = m_win ? 2 : 1;
        end else if (bus.shot_valid && m_state == 1) begin
            i = int'(bus.shot_idx);
            m_rv = 1;
            if (i < C) begin
                m_rh = m_ship[i];
                m_rr = m_shot[i];
                m_shot[i] = 1;
                if (m_ship[i]) m_hit[i] = 1;
            end
            if (!(RF && m_rr) && m_left > 0) m_left--;
            if (all_sunk()) begin m_state = 2; m_win = 1; end
            else if (m_left == 0) m_state = 2;
        end
        m_hits_vec = 0;
        m_count = 0;
        for (int k = 0; k < C; k++) if (m_hit[k]) begin m_hits_vec += (1 << k); m_count++; end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [C-1:0] m, input logic v, input logic [IW-1:0] i);
        rstn = r; start = s; map_input = m; bus.shot_valid = v; bus.shot_idx = i;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("shot_ready", int'(bus.shot_ready), int'(m_state == 1));
            chk("resp_valid", int'(bus.resp_valid), int'(m_rv));
            chk("resp_hit", int'(bus.resp_hit), int'(m_rh));
            chk("resp_repeat", int'(bus.resp_repeat), int'(m_rr));
            chk("hits", int'(hits), m_hits_vec);
            chk("hit_count", int'(hit_count), m_count);
            chk("shots_left", int'(shots_left), m_left);
            chk("game_over", int'(game_over), int'(m_state == 2));
            chk("win", int'(win), int'(m_win));
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_hits", int'(hits), 0);
        chk("rst_shots_left", int'(shots_left), 0);
        chk("rst_ready", int'(bus.shot_ready), 0);
        // reset in the middle of a game
        cyc(0, 1, 5'b10101, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 2);
        chk("t1_hits", int'(hits), 5);
        chk("t1_model_hits", m_hits_vec, 5);
        cyc(1, 0, 0, 1, 1);
        chk("t1_hits0", int'(hits), 0);
        chk("t1_left0", int'(shots_left), 0);
        chk("t1_ready0", int'(bus.shot_ready), 0);
        chk("t1_resp0", int'(bus.resp_valid), 0);
        cyc(0, 0, 0, 1, 1);
        chk("t1_resp1", int'(bus.resp_valid), 0);
        // sink both ships
        cyc(0, 1, 5'b10010, 0, 0);
        chk("t2_model_left", m_left, SM);
        cyc(0, 0, 0, 1, 1);
        chk("t2_hit_a", int'(bus.resp_hit), 1);
        chk("t2_count_a", int'(hit_count), 1);
        chk("t2_over_a", int'(game_over), 0);
        cyc(0, 0, 0, 1, 4);
        chk("t2_hit_b", int'(bus.resp_hit), 1);
        chk("t2_count_b", int'(hit_count), 2);
        chk("t2_win", int'(win), 1);
        chk("t2_over", int'(game_over), 1);
        chk("t2_ready", int'(bus.shot_ready), 0);
        // hammer one empty cell
        cyc(0, 1, 5'b00001, 0, 0);
        for (int k = 0; k < SM; k++) begin
            cyc(0, 0, 0, 1, 3);
            chk("t3_repeat", int'(bus.resp_repeat), int'(k > 0));
        end
        if (RF) begin
            chk("t3_left_free", int'(shots_left), 7);
            chk("t3_ready_free", int'(bus.shot_ready), 1);
        end else begin
            chk("t3_over", int'(game_over), 1);
            chk("t3_win", int'(win), 0);
        end
        // out-of-range target
        cyc(0, 1, 5'b00001, 0, 0);
        cyc(0, 0, 0, 1, 7);
        chk("t4_valid", int'(bus.resp_valid), 1);
        chk("t4_hit", int'(bus.resp_hit), 0);
        chk("t4_repeat", int'(bus.resp_repeat), 0);
        chk("t4_left", int'(shots_left), 7);
        chk("t4_hits", int'(hits), 0);
        // start collides with a shot
        cyc(0, 0, 0, 1, 3);
        cyc(0, 1, 5'b00011, 1, 0);
        chk("t5_resp", int'(bus.resp_valid), 0);
        chk("t5_left", int'(shots_left), SM);
        chk("t5_ready", int'(bus.shot_ready), 1);
        chk("t5_hits", int'(hits), 0);
        // empty map wins at once
        cyc(0, 1, 5'b00000, 1, 0);
        chk("t6_over", int'(game_over), 1);
        chk("t6_win", int'(win), 1);
        chk("t6_ready", int'(bus.shot_ready), 0);
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(63) == 0, $urandom_range(15) == 0, C'($urandom & $urandom),
                $urandom_range(3) != 0, IW'($urandom));
        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
